dmem_arbiter: RTL

- Arbitrates the single-port 32x32 data memory between two requesters: the pipeline MEM stage (cpu) and a DMA/debug loader port (dma).
- Registers each granted access, drives the memory's write-enable/address/data lines for exactly one cycle, captures read data, and returns a one-cycle ack.
- Stalls the pipeline while the cpu access is outstanding.
- Sits between the MEM stage and the data memory; the memory itself is unchanged (combinational read, write when enable=1).

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_arbiter_rr_arb2.sv | 30 +++
 rtl/dmem_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory arbiter.
//   DEPTH/ADDR_W/DATA_W : memory geometry (32 words x 32 bits)
//   state_e             : arbiter FSM states
//   req_e               : requester identity (cpu = 0, dma = 1)
package dmem_pkg;

    localparam int unsigned DEPTH  = 32;
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_e;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DMA = 1'b1
    } req_e;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin picker.
//   req_i[0]     : cpu request
//   req_i[1]     : dma request
//   last_grant_i : requester granted most recently
//   winner_o     : requester to grant (only meaningful when |req_i)
module rr_arb2
    import dmem_pkg::*;
(
    input  logic [1:0] req_i,
    input  req_e       last_grant_i,
    output req_e       winner_o
);

    always_comb begin
        winner_o = REQ_CPU;
        case (req_i)
            2'b10: winner_o = REQ_DMA;
            2'b11: begin
                // Tie: hand the grant to whoever did not win last time.
                if (last_grant_i == REQ_CPU) begin
                    winner_o = REQ_DMA;
                end else begin
                    winner_o = REQ_CPU;
                end
            end
            default: winner_o = REQ_CPU;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port 32x32 data memory between the
// pipeline MEM stage (cpu_*) and a DMA/debug loader (dma_*).
// Each grant runs IDLE -> ACCESS -> DONE; the memory is driven for the one
// ACCESS cycle, read data is captured at its closing edge, and the winner
// sees a registered one-cycle ack (with rdata/err) right after DONE.
//   clk, rst_n           : clock, async active-low reset
//   cpu_req/we/addr/wdata: cpu request, held until cpu_ack
//   cpu_rdata/ack/err    : cpu response, valid while cpu_ack=1
//   cpu_stall            : cpu_req & ~cpu_ack
//   dma_*                : same as cpu_* (no stall)
//   mem_we/addr/wdata    : to memory (mem_we pulses only in ACCESS)
//   mem_rdata            : combinational read data from memory
// Build option: define DMEM_ADDR_CHECK_EN to flag addr >= DEPTH as an error
// (no write, rdata 0, err with ack); otherwise addr wraps to ADDR_W bits.
module dmem_arbiter
    import dmem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_err,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [31:0]       dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    output logic              dma_err,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e              state_q;
    req_e                last_grant_q;
    req_e                winner_q;
    logic                we_q;
    logic                err_q;
    logic [DATA_W-1:0]   cap_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                cpu_ack_q, dma_ack_q;
    logic                cpu_err_q, dma_err_q;
    logic [DATA_W-1:0]   cpu_rdata_q, dma_rdata_q;

    req_e                winner;
    logic                sel_we;
    logic [31:0]         sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_err_d;

    rr_arb2 u_rr_arb2 (
        .req_i        ({dma_req, cpu_req}),
        .last_grant_i (last_grant_q),
        .winner_o     (winner)
    );

    always_comb begin
        sel_we    = cpu_we;
        sel_addr  = cpu_addr;
        sel_wdata = cpu_wdata;
        if (winner == REQ_DMA) begin
            sel_we    = dma_we;
            sel_addr  = dma_addr;
            sel_wdata = dma_wdata;
        end
    end

`ifdef DMEM_ADDR_CHECK_EN
    assign sel_err_d = (sel_addr >= DEPTH);
`else
    // Upper address bits are deliberately dropped (wrap-around).
    logic addr_hi_unused;
    assign addr_hi_unused = |sel_addr[31:ADDR_W];
    assign sel_err_d      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= REQ_DMA;
            winner_q     <= REQ_CPU;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            cap_q        <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_ack_q    <= 1'b0;
            dma_ack_q    <= 1'b0;
            cpu_err_q    <= 1'b0;
            dma_err_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
        end else begin
            // Responses and the write strobe are single-cycle pulses.
            mem_we_q    <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            cpu_err_q   <= 1'b0;
            dma_err_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
            case (state_q)
                IDLE: begin
                    if (cpu_req || dma_req) begin
                        // mem_* registers double as the latched request, so
                        // they hold their value outside ACCESS.
                        winner_q    <= winner;
                        we_q        <= sel_we;
                        err_q       <= sel_err_d;
                        mem_we_q    <= sel_we & ~sel_err_d;
                        mem_addr_q  <= sel_addr[ADDR_W-1:0];
                        mem_wdata_q <= sel_wdata;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    cap_q   <= (we_q || err_q) ? '0 : mem_rdata;
                    state_q <= DONE;
                end
                DONE: begin
                    if (winner_q == REQ_CPU) begin
                        cpu_ack_q   <= 1'b1;
                        cpu_err_q   <= err_q;
                        cpu_rdata_q <= cap_q;
                    end else begin
                        dma_ack_q   <= 1'b1;
                        dma_err_q   <= err_q;
                        dma_rdata_q <= cap_q;
                    end
                    last_grant_q <= winner_q;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = 32'(mem_addr_q);
    assign mem_wdata = mem_wdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign cpu_err   = cpu_err_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_ack   = dma_ack_q;
    assign dma_err   = dma_err_q;
    assign dma_rdata = dma_rdata_q;
    assign cpu_stall = cpu_req & ~cpu_ack_q;

endmodule
